// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings
// and the pipeline depth limit.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLL  = 3'b101,
        OP_SRL  = 3'b110,
        OP_SLTU = 3'b111
    } op_e;

    localparam int STAGES_MAX = 4;

endpackage

// File: rtl/alu_pipe_slice.sv
// One pipeline slice: a valid bit plus the packed {Y,C,Z,V} result,
// loaded whenever the enclosing pipeline grants it a load.
module alu_pipe_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             vld_i,
    input  logic [WIDTH+2:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH+2:0] dat_o
);

    logic             vld_q, vld_d;
    logic [WIDTH+2:0] dat_q, dat_d;

    // Data only moves with a real result so an empty slice keeps
    // its last value instead of tracking idle operands.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (ld_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                dat_d = dat_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready on both sides; the result is
// computed at capture and carried through STAGES slices.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             Z,
    output logic             V
);

    localparam int DW  = WIDTH + 3;
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    logic [DW-1:0]    alu_res;

    always_comb begin
        sum = {1'b0, A} + {1'b0, B};
        dif = {1'b0, A} - {1'b0, B};
        sh  = B[SHW-1:0];
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op_e'(OP))
            OP_ADD: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (A[WIDTH-1] == B[WIDTH-1]) &&
                    (y[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                y = dif[WIDTH-1:0];
                c = dif[WIDTH];
                v = (A[WIDTH-1] != B[WIDTH-1]) &&
                    (y[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  y = A & B;
            OP_OR:   y = A | B;
            OP_XOR:  y = A ^ B;
            OP_SLL:  y = A << sh;
            OP_SRL:  y = A >> sh;
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
            default: y = '0;
        endcase
        alu_res = {y, c, (y == '0), v};
    end

    logic          vq [STAGES];
    logic [DW-1:0] dq [STAGES];
    logic          ld [STAGES];
    logic          acc;

    // Slice k may load if any slice from k to the output is empty
    // or the sink pops; built from registered valids only.
    always_comb begin
        acc = out_ready;
        for (int k = 0; k < STAGES; k++) begin
            ld[k] = 1'b0;
        end
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc   = acc | ~vq[k];
            ld[k] = acc & ~rst;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_sl
        logic          vi;
        logic [DW-1:0] di;
        if (k == 0) begin : g_head
            assign vi = in_valid;
            assign di = alu_res;
        end else begin : g_body
            assign vi = vq[k-1];
            assign di = dq[k-1];
        end
        alu_pipe_slice #(
            .WIDTH (WIDTH)
        ) u_slice (
            .clk   (clk),
            .rst   (rst),
            .ld_i  (ld[k]),
            .vld_i (vi),
            .dat_i (di),
            .vld_o (vq[k]),
            .dat_o (dq[k])
        );
    end

    assign in_ready     = ld[0];
    assign out_valid    = vq[STAGES-1];
    assign {Y, C, Z, V} = dq[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed op/flag cases,
// backpressure, mid-flight reset and a random stream.
module tb_alu_pipe;

    localparam int W  = 8;
    localparam int ST = 2;
    localparam int RW = W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [2:0]   OP;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         C, Z, V;

    alu_pipe #(
        .WIDTH  (W),
        .STAGES (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .C         (C),
        .Z         (Z),
        .V         (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] r;
        int            cyc;
    } ent_t;

    ent_t          q [$];
    logic [RW-1:0] cur_exp;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    bit            lat_en = 0;
    bit            hold_v = 0;
    logic [RW:0]   hold_d;
    bit            rnd_done;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] pk(input logic [W-1:0] y,
                                         input logic c, input logic z,
                                         input logic v);
        return {y, c, z, v};
    endfunction

    function automatic logic [RW-1:0] model(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint m, la, lb, sa, sb, sr, s;
        int sh;
        logic [W-1:0] y;
        logic c, v;
        m  = longint'(1) << W;
        la = longint'(a);
        lb = longint'(b);
        sa = (la >= m / 2) ? la - m : la;
        sb = (lb >= m / 2) ? lb - m : lb;
        sh = int'(b[$clog2(W)-1:0]);
        c  = 1'b0;
        v  = 1'b0;
        sr = 0;
        y  = '0;
        case (op)
            3'd0: begin
                s  = la + lb;
                y  = W'(s % m);
                c  = (s >= m);
                sr = sa + sb;
                v  = (sr >= m / 2) || (sr < -(m / 2));
            end
            3'd1: begin
                y  = W'((la - lb + m) % m);
                c  = (la < lb);
                sr = sa - sb;
                v  = (sr >= m / 2) || (sr < -(m / 2));
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = W'(la << sh);
            3'd6: y = W'(la >> sh);
            default: y = (la < lb) ? W'(1) : W'(0);
        endcase
        return pk(y, c, (y == 0), v);
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            q.delete();
            hold_v = 0;
        end else begin
            check("in_ready", in_ready,
                  (q.size() < ST) || out_ready);
            if (hold_v) begin
                check("hold", {out_valid, Y, C, Z, V}, hold_d);
            end
            hold_v = out_valid && !out_ready;
            hold_d = {out_valid, Y, C, Z, V};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("result", {Y, C, Z, V}, e.r);
                    if (lat_en) begin
                        check("latency", cyc - e.cyc, ST);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.r   = cur_exp;
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [RW-1:0] e);
        int t;
        bit done;
        in_valid = 1'b1;
        OP       = op;
        A        = a;
        B        = b;
        cur_exp  = e;
        t        = 0;
        done     = 0;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 200) begin
                check("send_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        OP        = '0;
        cur_exp   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", {Y, C, Z, V}, 0);
        check("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;

        lat_en = 1;
        send(3'd0, 8'd10,  8'd5,   pk(8'd15,  0, 0, 0));
        send(3'd1, 8'd20,  8'd7,   pk(8'd13,  0, 0, 0));
        send(3'd0, 8'd200, 8'd100, pk(8'd44,  1, 0, 0));
        send(3'd0, 8'd100, 8'd50,  pk(8'd150, 0, 0, 1));
        send(3'd1, 8'd5,   8'd7,   pk(8'd254, 1, 0, 0));
        send(3'd1, 8'd9,   8'd9,   pk(8'd0,   0, 1, 0));
        send(3'd2, 8'hAA,  8'hCC,  pk(8'h88,  0, 0, 0));
        send(3'd3, 8'hAA,  8'hCC,  pk(8'hEE,  0, 0, 0));
        send(3'd4, 8'hAA,  8'hCC,  pk(8'h66,  0, 0, 0));
        send(3'd5, 8'h81,  8'd1,   pk(8'h02,  0, 0, 0));
        send(3'd6, 8'h81,  8'd9,   pk(8'h40,  0, 0, 0));
        send(3'd7, 8'd3,   8'd4,   pk(8'd1,   0, 0, 0));
        drain();
        lat_en = 0;

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    a = W'(17 * i + 3);
                    b = W'(5 * i + 1);
                    op = 3'(i);
                    send(op, a, b, model(op, a, b));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(3'd0, 8'd1, 8'd2, pk(8'd3, 0, 0, 0));
        send(3'd0, 8'd3, 8'd4, pk(8'd7, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_flags", {Y, C, Z, V}, 0);
        check("mid_rst_ready", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    op = 3'($urandom_range(7));
                    a  = W'($urandom);
                    b  = W'($urandom);
                    send(op, a, b, model(op, a, b));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(1));
                end
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
